fft_mm_master: RTL and testbench

- PicoMm initiator that drives the memory-mapped FFT slave end to end: streams N complex samples into the slave data window, starts the transform through the control port, waits for irq, acknowledges it, then reads natural-order results back out as a stream.
- Sits between a sample source/sink (ADC framer, DMA) and the FFT slave, and replaces the software sequence the bench currently performs.

---
 rtl/fft_mm_master.sv | 143 ++++++++++++++
 tb/tb_fft_mm_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mm_master.sv
// PicoMm initiator for the memory-mapped FFT slave: loads N complex samples,
// starts the transform, waits for irq, acks it and streams natural-order bins out.
module fft_mm_master #(
  parameter int M  = 8,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_last,
  output logic [M+1:0]         d_addr,
  output logic                 d_write,
  output logic                 d_read,
  output logic [31:0]          d_wrdata,
  input  logic [31:0]          d_rddata,
  output logic                 c_write,
  output logic [31:0]          c_wrdata,
  input  logic                 irq,
  output logic                 irq_ack
);

  typedef enum logic [3:0] {
    IDLE, LD_RE, LD_IM, START, WAIT, ACK, RD_RE, RD_IM, CAP, HOLD
  } state_t;

  state_t        state, state_nx;
  logic [M-1:0]  n;
  logic [1:0]    mode_q;
  logic [DW-1:0] im_q;
  logic          last_n;

  assign last_n = &n;
  assign busy   = (state != IDLE);

  function automatic logic [31:0] sext(input logic [DW-1:0] v);
    return {{(32-DW){v[DW-1]}}, v};
  endfunction

  // Upper half of the data window (address bit M+1) is the bit-reversed
  // result region, so reading it in order yields natural-order bins.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    d_write  = 1'b0;
    d_read   = 1'b0;
    d_addr   = '0;
    d_wrdata = '0;
    c_write  = 1'b0;
    c_wrdata = '0;
    irq_ack  = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = LD_RE;
      LD_RE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          d_write  = 1'b1;
          d_addr   = {1'b0, n, 1'b0};
          d_wrdata = sext(in_re);
          state_nx = LD_IM;
        end
      end
      LD_IM: begin
        d_write  = 1'b1;
        d_addr   = {1'b0, n, 1'b1};
        d_wrdata = sext(im_q);
        state_nx = last_n ? START : LD_RE;
      end
      START: begin
        c_write  = 1'b1;
        c_wrdata = {30'b0, mode_q};
        state_nx = WAIT;
      end
      WAIT:  if (irq) state_nx = ACK;
      ACK: begin
        irq_ack  = 1'b1;
        state_nx = RD_RE;
      end
      RD_RE: begin
        d_read   = 1'b1;
        d_addr   = {1'b1, n, 1'b0};
        state_nx = RD_IM;
      end
      RD_IM: begin
        d_read   = 1'b1;
        d_addr   = {1'b1, n, 1'b1};
        state_nx = CAP;
      end
      CAP:   state_nx = HOLD;
      HOLD:  if (out_ready) state_nx = last_n ? IDLE : RD_RE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      mode_q    <= '0;
      im_q      <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == HOLD) && out_ready && last_n;
      case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          n      <= '0;
        end
        LD_RE: if (in_valid) im_q <= in_im;
        LD_IM: n <= last_n ? '0 : n + 1'b1;
        // read data lags its strobe by one cycle
        RD_IM: out_re <= d_rddata[DW-1:0];
        CAP: begin
          out_im    <= d_rddata[DW-1:0];
          out_valid <= 1'b1;
          out_last  <= last_n;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          n         <= last_n ? '0 : n + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_mm_master.sv
// Bench for fft_mm_master: a behavioural PicoMm FFT-slave stand-in plus a
// single-process driver/monitor checking bus traffic and streamed bins.
module tb_fft_mm_master;
  localparam int M  = 8;
  localparam int N  = 1 << M;
  localparam int DW = 16;

  logic clk = 0, rst = 1;
  logic start = 0, in_valid = 0, out_ready = 0;
  logic [1:0] mode = 0;
  logic signed [DW-1:0] in_re = 0, in_im = 0;
  logic busy, done, in_ready, out_valid, out_last;
  logic signed [DW-1:0] out_re, out_im;
  logic [M+1:0] d_addr;
  logic d_write, d_read, c_write, irq_ack;
  logic [31:0] d_wrdata, d_rddata, c_wrdata;
  logic irq;

  fft_mm_master #(.M(M), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .d_addr(d_addr), .d_write(d_write), .d_read(d_read),
    .d_wrdata(d_wrdata), .d_rddata(d_rddata), .c_write(c_write), .c_wrdata(c_wrdata),
    .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // Slave stand-in: result bin k = (im[k] + 1000*mode, re[k] ^ k), junk upper bits.
  logic [31:0] mem [0:4*N-1];
  int irq_lat = 10;
  int irq_cnt;

  always @(posedge clk) begin
    if (d_write) mem[d_addr] <= d_wrdata;
    if (c_write)
      for (int k = 0; k < N; k++) begin
        mem[2*N+2*k]   <= {16'hA5A5, mem[2*k+1][15:0] + 16'(1000*int'(c_wrdata[1:0]))};
        mem[2*N+2*k+1] <= {16'h5A5A, mem[2*k][15:0] ^ 16'(k)};
      end
    d_rddata <= d_read ? mem[d_addr] : 32'hDEADBEEF;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      irq     <= 1'b0;
      irq_cnt <= 0;
    end else begin
      if (c_write) begin
        if (irq_lat == 0) irq <= 1'b1;
        else irq_cnt <= irq_lat;
      end else if (irq_cnt > 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1) irq <= 1'b1;
      end
      if (irq_ack) irq <= 1'b0;
    end
  end

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  logic signed [DW-1:0] src_re [N];
  logic signed [DW-1:0] src_im [N];
  logic [1:0] cur_mode;
  int wr_idx, rd_idx, cwr_cnt = 0, ack_cnt = 0, done_cnt = 0, cyc = 0, irq_first;
  logic s_in_ready, s_out_valid, s_out_last, s_d_write, s_d_read, s_c_write, s_done, s_busy;
  logic signed [DW-1:0] s_out_re, s_out_im;

  function automatic logic [31:0] sext(input logic signed [DW-1:0] v);
    return 32'(v);
  endfunction

  function automatic logic [15:0] mdl_re(input int k, input logic [1:0] md);
    return src_im[k] + 16'(1000*int'(md));
  endfunction

  function automatic logic [15:0] mdl_im(input int k);
    return src_re[k] ^ 16'(k);
  endfunction

  // One clock: sample and check at negedge, return just after the next posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_in_ready = in_ready;  s_out_valid = out_valid; s_out_last = out_last;
    s_out_re   = out_re;    s_out_im    = out_im;    s_d_write  = d_write;
    s_d_read   = d_read;    s_c_write   = c_write;   s_done     = done;
    s_busy     = busy;
    if (!rst) begin
      check("excl", 32'((int'(d_write) + int'(d_read) + int'(c_write)) > 1), 0);
      if (!d_write) check("wdata_idle", d_wrdata, 0);
      if (!d_write && !d_read) check("addr_idle", 32'(d_addr), 0);
      if (d_write) begin
        if (wr_idx < 2*N) begin
          check("wr_addr", 32'(d_addr), 32'(wr_idx));
          check("wr_data", d_wrdata,
                (wr_idx % 2 == 0) ? sext(src_re[wr_idx/2]) : sext(src_im[wr_idx/2]));
        end else check("wr_extra", 32'(wr_idx), 32'(2*N-1));
        wr_idx++;
      end
      if (d_read) begin
        if (rd_idx < 2*N) check("rd_addr", 32'(d_addr), 32'(2*N + rd_idx));
        else check("rd_extra", 32'(rd_idx), 32'(2*N-1));
        rd_idx++;
      end
      if (c_write) begin
        check("cwr_data", c_wrdata, {30'b0, cur_mode});
        cwr_cnt++;
      end
      if (irq && irq_first < 0) irq_first = cyc;
      if (irq_ack) begin
        check("ack_delay", 32'(cyc - irq_first), 1);
        ack_cnt++;
      end
      if (out_valid) check("hold_rd", 32'(d_read), 0);
      if (done) done_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_rst_outs(input string tag);
    check({tag, "_ctl"}, 32'({busy, done, in_ready, out_valid, out_last,
                              d_write, d_read, c_write, irq_ack}), 0);
    check({tag, "_out"}, {out_re, out_im}, 0);
    check({tag, "_addr"}, 32'(d_addr), 0);
    check({tag, "_wd"}, d_wrdata, 0);
    check({tag, "_cwd"}, c_wrdata, 0);
  endtask

  task automatic feed(input int gap_at);
    int cnt;
    for (int i = 0; i < N; i++) begin
      in_valid = 1; in_re = src_re[i]; in_im = src_im[i];
      cnt = 0;
      do begin tick(); cnt++; end while (!s_in_ready && cnt < 2000);
      if (!s_in_ready) begin check("feed_timeout", 0, 1); in_valid = 0; return; end
      in_valid = 0; in_re = DW'($urandom); in_im = DW'($urandom);
      if (i == gap_at) begin
        tick(); check("gap_im_wr", 32'(s_d_write), 1);
        repeat (3) begin tick(); check("gap_nowr", 32'(s_d_write), 0); end
      end
    end
  endtask

  task automatic collect(input int bp_bin, input bit rand_bp);
    int cnt, h;
    bit hs;
    for (int k = 0; k < N; k++) begin
      out_ready = (k == bp_bin) ? 1'b0 : (rand_bp ? ($urandom % 3 != 0) : 1'b1);
      cnt = 0;
      do begin tick(); cnt++; end while (!s_out_valid && cnt < 2000);
      if (!s_out_valid) begin check("out_timeout", 0, 1); return; end
      check("bin_re", 32'(s_out_re), 32'(signed'(mdl_re(k, cur_mode))));
      check("bin_im", 32'(s_out_im), 32'(signed'(mdl_im(k))));
      check("bin_last", 32'(s_out_last), 32'(k == N-1));
      hs = out_ready; h = 0;
      while (!hs && h < 1000) begin
        h++;
        out_ready = (k == bp_bin) ? (h >= 5) : ($urandom % 2 == 1);
        tick();
        check("hold_vld", 32'(s_out_valid), 1);
        check("hold_re", 32'(s_out_re), 32'(signed'(mdl_re(k, cur_mode))));
        check("hold_im", 32'(s_out_im), 32'(signed'(mdl_im(k))));
        hs = out_ready;
      end
      if (k == N-1) begin
        out_ready = 0;
        tick();
        check("done_pulse", 32'(s_done), 1);
        check("busy_end", 32'(s_busy), 0);
        check("vld_end", 32'(s_out_valid), 0);
      end
    end
  endtask

  task automatic run_frame(input logic [1:0] md, input int gap_at, input int bp_bin,
                           input bit rand_bp, input int lat, input bit abuse, input bit abort);
    int c0, a0, d0, cnt;
    wr_idx = 0; rd_idx = 0; irq_first = -1; cur_mode = md; irq_lat = lat;
    c0 = cwr_cnt; a0 = ack_cnt; d0 = done_cnt;
    start = 1; mode = md;
    tick();
    start = 0; mode = 2'($urandom);
    feed(gap_at);
    cnt = 0;
    do begin tick(); cnt++; end while (!s_c_write && cnt < 100);
    check("cwr_seen", 32'(s_c_write), 1);
    if (abuse) begin
      tick();
      start = 1; mode = ~md;
      tick();
      start = 0;
      check("abuse_busy", 32'(s_busy), 1);
    end
    if (abort) begin
      tick(); tick();
      rst = 1; #1;
      check_rst_outs("abort");
      tick();
      rst = 0;
      tick();
      check("abort_idle", 32'(s_busy), 0);
      return;
    end
    collect(bp_bin, rand_bp);
    check("wr_total", 32'(wr_idx), 32'(2*N));
    check("rd_total", 32'(rd_idx), 32'(2*N));
    check("cwr_cnt", 32'(cwr_cnt - c0), 1);
    check("ack_cnt", 32'(ack_cnt - a0), 1);
    check("done_cnt", 32'(done_cnt - d0), 1);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) begin
      src_re[i] = DW'($urandom);
      src_im[i] = DW'($urandom);
    end
  endtask

  initial begin
    #1;
    check_rst_outs("reset");
    repeat (3) @(posedge clk);
    #1;
    check_rst_outs("reset_hold");
    rst = 0;
    tick();
    check("idle_busy", 32'(s_busy), 0);
    check("idle_rdy", 32'(s_in_ready), 0);

    for (int i = 0; i < N; i++) begin
      src_re[i] = (i < N/2) ? 16'sd10000 : -16'sd10000;
      src_im[i] = 0;
    end
    run_frame(2'd0, -1, -1, 1'b0, 10, 1'b0, 1'b0);

    rand_frame();
    run_frame(2'd1, 5, 10, 1'b1, 0, 1'b0, 1'b0);

    rand_frame();
    run_frame(2'd2, -1, -1, 1'b1, 30, 1'b1, 1'b0);

    rand_frame();
    run_frame(2'd3, -1, -1, 1'b0, 40, 1'b0, 1'b1);

    rand_frame();
    run_frame(2'd3, -1, 20, 1'b1, 5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
